// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, request kinds
// and the internal error-cause encoding.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CONFLICT,
    ERR_ALIGN,
    ERR_RANGE
  } err_e;

  // Cause priority: conflicting strobes, then alignment, then range.
  function automatic err_e classify(input logic        rd,
                                    input logic        wr,
                                    input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    if (rd && wr)                             return ERR_CONFLICT;
    else if (addr[1:0] != 2'b00)              return ERR_ALIGN;
    else if (addr < base || (off >> 2) >= depth) return ERR_RANGE;
    else                                      return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 backing store: synchronous write, asynchronous read, no reset.
module dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one word access at a time with a fixed
// wait-state latency, a one-cycle Ready_o pulse and pipeline stall.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WrData_i,
  output logic [31:0] RdData_o,
  output logic        Ready_o,
  output logic        Stall_o,
  output logic        Err_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  req_e        type_q, type_d;
  err_e        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, errout_q;

  logic        req;
  req_e        req_type;
  err_e        req_err;
  logic [31:0] cur_addr, cur_wdata;
  req_e        cur_type;
  err_e        cur_err;
  logic        enter_resp;
  logic        arr_we;
  logic [AW-1:0] arr_idx;
  logic [31:0] arr_rdata;

  assign req      = MemRd_i | MemWr_i;
  assign req_type = MemWr_i ? REQ_WR : REQ_RD;
  assign req_err  = classify(MemRd_i, MemWr_i, Addr_i, ADDR_BASE, DEPTH_W);

  // With zero wait states the response edge is also the accepting edge,
  // so the live request feeds the array/response path while in IDLE.
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_type  = type_q;
    cur_err   = err_q;
    if (state_q == IDLE) begin
      cur_addr  = Addr_i;
      cur_wdata = WrData_i;
      cur_type  = req_type;
      cur_err   = req_err;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = Addr_i;
          wdata_d = WrData_i;
          type_d  = req_type;
          err_d   = req_err;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP);
  assign arr_idx    = AW'((cur_addr - ADDR_BASE) >> 2);
  assign arr_we     = enter_resp && (cur_type == REQ_WR) && (cur_err == ERR_NONE) && !rst_i;
  assign rdata_d    = (cur_type == REQ_RD && cur_err == ERR_NONE) ? arr_rdata : '0;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (arr_we),
    .waddr_i(arr_idx),
    .wdata_i(cur_wdata),
    .raddr_i(arr_idx),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      type_q   <= REQ_RD;
      err_q    <= ERR_NONE;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      errout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      type_q   <= type_d;
      err_q    <= err_d;
      ready_q  <= enter_resp;
      errout_q <= enter_resp && (cur_err != ERR_NONE);
      if (enter_resp) rdata_q <= rdata_d;
    end
  end

  assign RdData_o = rdata_q;
  assign Ready_o  = ready_q;
  assign Err_o    = errout_q;
  assign Stall_o  = !rst_i && (((state_q == IDLE) && req) || (state_q == WAIT));

endmodule
